rx_module: RTL and testbench

//  UART receive engine; counterpart of the transmit module on the same link.

---
 rtl/rx_module.sv | 151 +++++++++++++++
 tb/tb_rx_module.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_module.sv
// UART receive engine: 16x oversampled, majority-voted bits, line idle=0/start=1,
// frames delivered with parity/frame/overrun status through a valid/ack handshake.
module rx_module #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       baud_en_i,
   input  logic       rx_en_i,
   input  logic [4:0] rx_conf_i,
   input  logic       uart_rx_i,
   input  logic       rx_ack_i,
   output logic [7:0] rx_data_o,
   output logic       rx_valid_o,
   output logic       rx_parity_err_o,
   output logic       rx_frame_err_o,
   output logic       rx_overrun_o
);

   typedef enum logic [2:0] {
      S_DISABLED = 3'd0,
      S_IDLE     = 3'd1,
      S_START    = 3'd2,
      S_DATA     = 3'd3,
      S_PARITY   = 3'd4,
      S_STOP     = 3'd5,
      S_DONE     = 3'd6
   } state_e;

   state_e                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   line;
   logic [3:0]             cnt_q;
   logic [2:0]             bit_q;
   logic [1:0]             dsize_q, ssize_q;
   logic                   pen_q;
   logic                   s7_q, s8_q;
   logic [7:0]             data_q;
   logic                   par_q, ferr_q;
   logic                   in_frame, decide, wrap, bit_val;
   logic                   start_det, publish;
   logic [2:0]             last_data;

   assign line      = sync_q[SYNC_STAGES-1];
   assign in_frame  = (state_q == S_START) || (state_q == S_DATA) ||
                      (state_q == S_PARITY) || (state_q == S_STOP);
   assign decide    = in_frame && (cnt_q == 4'd9);
   assign wrap      = in_frame && (cnt_q == 4'd15);
   // samples at cnt 7 and 8 are held; the cnt 9 sample is the live line
   assign bit_val   = (s7_q & s8_q) | (s7_q & line) | (s8_q & line);
   assign last_data = 3'd4 + {1'b0, dsize_q};
   assign start_det = baud_en_i && (state_q == S_IDLE) && (state_d == S_START);
   assign publish   = baud_en_i && (state_q == S_DONE);

   always_ff @(posedge clk_i) begin
      if (!rst_ni) sync_q <= '0;
      else         sync_q <= {sync_q[SYNC_STAGES-2:0], uart_rx_i};
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) state_q <= S_DISABLED;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (baud_en_i) begin
         case (state_q)
            S_DISABLED: if (rx_en_i) state_d = S_IDLE;
            S_IDLE: begin
               if (!rx_en_i)  state_d = S_DISABLED;
               else if (line) state_d = S_START;
            end
            S_START: begin
               if (decide && !bit_val) state_d = S_IDLE;
               else if (wrap)          state_d = S_DATA;
            end
            S_DATA:   if (wrap && (bit_q == last_data)) state_d = pen_q ? S_PARITY : S_STOP;
            S_PARITY: if (wrap) state_d = S_STOP;
            // the trailing half of the last stop bit is not waited for
            S_STOP:   if (decide && (bit_q == {1'b0, ssize_q})) state_d = S_DONE;
            S_DONE:   state_d = rx_en_i ? S_IDLE : S_DISABLED;
            default:  state_d = S_DISABLED;
         endcase
         if (in_frame && !rx_en_i) state_d = S_DISABLED;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         cnt_q   <= '0;
         bit_q   <= '0;
         dsize_q <= '0;
         ssize_q <= '0;
         pen_q   <= 1'b0;
         s7_q    <= 1'b0;
         s8_q    <= 1'b0;
         data_q  <= '0;
         par_q   <= 1'b0;
         ferr_q  <= 1'b0;
      end else if (baud_en_i) begin
         if (start_det) begin
            // detection tick is sample 0 of the start bit
            cnt_q                      <= 4'd1;
            bit_q                      <= '0;
            {dsize_q, ssize_q, pen_q}  <= rx_conf_i;
            data_q                     <= '0;
            par_q                      <= 1'b0;
            ferr_q                     <= 1'b0;
         end else if (in_frame) begin
            cnt_q <= cnt_q + 4'd1;
            if (cnt_q == 4'd7) s7_q <= line;
            if (cnt_q == 4'd8) s8_q <= line;
            if (decide) begin
               case (state_q)
                  S_DATA:   data_q[bit_q] <= bit_val;
                  S_PARITY: par_q <= bit_val;
                  S_STOP:   if (bit_val) ferr_q <= 1'b1;
                  default:  ;
               endcase
            end
            // index restarts whenever the bit field (data/parity/stop) changes
            if (wrap) bit_q <= (state_d == state_q) ? bit_q + 3'd1 : 3'd0;
         end else begin
            cnt_q <= '0;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         rx_data_o       <= '0;
         rx_valid_o      <= 1'b0;
         rx_parity_err_o <= 1'b0;
         rx_frame_err_o  <= 1'b0;
         rx_overrun_o    <= 1'b0;
      end else if (publish) begin
         rx_data_o       <= data_q;
         rx_parity_err_o <= pen_q & (^data_q ^ par_q);
         rx_frame_err_o  <= ferr_q;
         rx_overrun_o    <= rx_valid_o & ~rx_ack_i;
         rx_valid_o      <= 1'b1;
      end else if (rx_ack_i && rx_valid_o) begin
         rx_valid_o      <= 1'b0;
         rx_parity_err_o <= 1'b0;
         rx_frame_err_o  <= 1'b0;
         rx_overrun_o    <= 1'b0;
      end
   end

endmodule

// File: tb/tb_rx_module.sv
// Bench for rx_module: frame-level reference model (publish schedule queue) checked
// every clock, plus directed literal checks and randomized frames.
module tb_rx_module;
   logic       clk = 1'b0, rst_n = 1'b0, baud_en = 1'b0, rx_en = 1'b0;
   logic       uart_rx = 1'b0, rx_ack = 1'b0;
   logic [4:0] rx_conf = '0;
   logic [7:0] rx_data;
   logic       rx_valid, rx_perr, rx_ferr, rx_ovr;

   int n_checks = 0, n_fail = 0;
   int tick_n = 0, div = 0, ack_at_tick = -1, rise_tick = 0;
   bit started = 0, ack_rand = 0, ack_once = 0, scramble = 0;

   typedef struct {
      int         tick;
      logic [7:0] data;
      logic       perr;
      logic       ferr;
   } pub_t;
   pub_t pend[$];

   logic [7:0] exp_data = '0;
   logic       exp_valid = 0, exp_perr = 0, exp_ferr = 0, exp_ovr = 0, prev_valid = 0;

   rx_module #(.SYNC_STAGES(2)) dut (
      .clk_i(clk), .rst_ni(rst_n), .baud_en_i(baud_en), .rx_en_i(rx_en),
      .rx_conf_i(rx_conf), .uart_rx_i(uart_rx), .rx_ack_i(rx_ack),
      .rx_data_o(rx_data), .rx_valid_o(rx_valid), .rx_parity_err_o(rx_perr),
      .rx_frame_err_o(rx_ferr), .rx_overrun_o(rx_ovr)
   );

   always #5 clk = ~clk;

   always begin
      @(posedge clk); #1;
      div = (div + 1) % 4;
      baud_en = (div == 0);
   end

   always begin
      @(posedge clk); #2;
      rx_ack = 1'b0;
      if (ack_once) begin rx_ack = 1'b1; ack_once = 0; end
      if (ack_rand && $urandom_range(0, 3) == 0) rx_ack = 1'b1;
      if (baud_en && ack_at_tick == tick_n + 1) rx_ack = 1'b1;
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (tick %0d)", name, got, exp, tick_n);
      end
   endtask

   // reference model: outputs change only at scheduled publish ticks, ack or reset
   always @(posedge clk) begin
      if (baud_en) tick_n++;
      if (!rst_n) begin
         started = 1;
         exp_data = '0; exp_valid = 0; exp_perr = 0; exp_ferr = 0; exp_ovr = 0;
         pend.delete();
      end else if (baud_en && pend.size() > 0 && pend[0].tick == tick_n) begin
         exp_ovr   = exp_valid & ~rx_ack;
         exp_data  = pend[0].data;
         exp_perr  = pend[0].perr;
         exp_ferr  = pend[0].ferr;
         exp_valid = 1'b1;
         void'(pend.pop_front());
      end else if (rx_ack && exp_valid) begin
         exp_valid = 0; exp_perr = 0; exp_ferr = 0; exp_ovr = 0;
      end
   end

   always @(negedge clk) begin
      if (started) begin
         chk("valid", 32'(rx_valid), 32'(exp_valid));
         chk("parity_err", 32'(rx_perr), 32'(exp_perr));
         chk("frame_err", 32'(rx_ferr), 32'(exp_ferr));
         chk("overrun", 32'(rx_ovr), 32'(exp_ovr));
         if (exp_valid) chk("data", 32'(rx_data), 32'(exp_data));
         if (rx_valid && !prev_valid) rise_tick = tick_n;
         prev_valid = rx_valid;
      end
   end

   task automatic wait_tick();
      do @(posedge clk); while (!baud_en);
      #2;
   endtask

   task automatic wait_ticks(input int n);
      repeat (n) wait_tick();
   endtask

   // abort: 0 none, 1 reset pulse during frame bit 4, 2 rx_en drop during frame bit 4
   task automatic send_frame(input logic [7:0] data, input logic [4:0] conf, input bit flip,
                             input logic [3:0] stop_ones, input int abort, input bit ack_pub,
                             output int t0);
      int nd, ns, e;
      logic [7:0] d;
      logic bits[$];
      logic ferr;
      pub_t p;
      nd = 5 + int'(conf[4:3]);
      ns = int'(conf[2:1]) + 1;
      d = data;
      for (int i = nd; i < 8; i++) d[i] = 1'b0;
      ferr = 1'b0;
      bits.push_back(1'b1);
      for (int i = 0; i < nd; i++) bits.push_back(d[i]);
      if (conf[0]) bits.push_back(^d ^ flip);
      for (int i = 0; i < ns; i++) begin
         bits.push_back(stop_ones[i]);
         ferr |= stop_ones[i];
      end
      rx_conf = conf;
      wait_tick();
      e = tick_n;
      t0 = e + 1;
      if (abort == 0) begin
         p.tick = t0 + 16 * (bits.size() - 1) + 10;
         p.data = d;
         p.perr = conf[0] & flip;
         p.ferr = ferr;
         pend.push_back(p);
         if (ack_pub) ack_at_tick = p.tick;
      end
      for (int b = 0; b < bits.size(); b++) begin
         uart_rx = bits[b];
         if (b == 1 && scramble) rx_conf = 5'($urandom);
         for (int t = 0; t < 16; t++) begin
            if (abort != 0 && b == 4 && t == 8) begin
               uart_rx = 1'b0;
               if (abort == 1) begin
                  rst_n = 1'b0;
                  @(posedge clk); #2;
                  rst_n = 1'b1;
               end else begin
                  rx_en = 1'b0;
                  wait_ticks(4);
                  rx_en = 1'b1;
               end
               return;
            end
            wait_tick();
         end
      end
      uart_rx = 1'b0;
      if (bits[bits.size() - 1]) wait_ticks(16);
   endtask

   task automatic do_ack();
      ack_once = 1;
      repeat (3) @(posedge clk);
      #2;
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0;
      logic [4:0] c;
      logic [3:0] so;
      repeat (3) @(posedge clk);
      #2;
      chk("reset_valid", 32'(rx_valid), 0);
      chk("reset_data", 32'(rx_data), 0);
      chk("reset_perr", 32'(rx_perr), 0);
      chk("reset_ferr", 32'(rx_ferr), 0);
      chk("reset_ovr", 32'(rx_ovr), 0);
      rst_n = 1'b1;
      rx_en = 1'b1;
      wait_ticks(4);

      send_frame(8'hA5, 5'b11_00_0, 0, 4'b0, 0, 0, t0);
      chk("a5_data", 32'(rx_data), 32'h A5);
      chk("a5_valid", 32'(rx_valid), 1);
      chk("a5_flags", 32'({rx_perr, rx_ferr, rx_ovr}), 0);
      chk("a5_latency", 32'(rise_tick - t0), 154);
      do_ack();
      chk("a5_ack_clears", 32'(rx_valid), 0);

      send_frame(8'h16, 5'b00_01_1, 0, 4'b0, 0, 0, t0);
      chk("p16_data", 32'(rx_data), 32'h16);
      chk("p16_perr", 32'(rx_perr), 0);
      do_ack();
      send_frame(8'h16, 5'b00_01_1, 1, 4'b0, 0, 0, t0);
      chk("p16_flip_perr", 32'(rx_perr), 1);
      chk("p16_flip_data", 32'(rx_data), 32'h16);
      do_ack();

      uart_rx = 1'b1;
      wait_ticks(4);
      uart_rx = 1'b0;
      wait_ticks(24);
      chk("false_start_valid", 32'(rx_valid), 0);
      send_frame(8'h3C, 5'b11_00_0, 0, 4'b0, 0, 0, t0);
      chk("after_false_data", 32'(rx_data), 32'h3C);
      chk("after_false_valid", 32'(rx_valid), 1);
      do_ack();

      send_frame(8'h81, 5'b11_00_0, 0, 4'b0001, 0, 0, t0);
      chk("ferr_data", 32'(rx_data), 32'h81);
      chk("ferr_flag", 32'(rx_ferr), 1);
      do_ack();

      send_frame(8'h11, 5'b11_00_0, 0, 4'b0, 0, 0, t0);
      send_frame(8'h22, 5'b11_00_0, 0, 4'b0, 0, 0, t0);
      chk("ovr_data", 32'(rx_data), 32'h22);
      chk("ovr_flag", 32'(rx_ovr), 1);
      do_ack();
      send_frame(8'h11, 5'b11_00_0, 0, 4'b0, 0, 0, t0);
      send_frame(8'h22, 5'b11_00_0, 0, 4'b0, 0, 1, t0);
      ack_at_tick = -1;
      chk("ack_pub_valid", 32'(rx_valid), 1);
      chk("ack_pub_ovr", 32'(rx_ovr), 0);
      chk("ack_pub_data", 32'(rx_data), 32'h22);

      send_frame(8'h5A, 5'b11_00_0, 0, 4'b0, 1, 0, t0);
      chk("midreset_outputs", 32'({rx_data, rx_valid, rx_perr, rx_ferr, rx_ovr}), 0);
      wait_ticks(30);
      chk("midreset_no_valid", 32'(rx_valid), 0);
      send_frame(8'h5A, 5'b11_00_0, 0, 4'b0, 2, 0, t0);
      wait_ticks(30);
      chk("rxen_drop_no_valid", 32'(rx_valid), 0);

      ack_rand = 1;
      scramble = 1;
      repeat (30) begin
         c  = 5'($urandom);
         so = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0;
         send_frame(8'($urandom), c, ($urandom_range(0, 3) == 0), so, 0, 0, t0);
         wait_ticks($urandom_range(0, 3));
      end
      ack_rand = 0;
      scramble = 0;
      wait_ticks(4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
